// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, 16x oversampled, valid/ack holding register.
// Macro UART_RX_PARITY_EN adds an even-parity bit (8E1) and a parity_err pulse.
//
// Ports:
//   sysclk      system clock, posedge
//   reset       async active-high reset
//   sam_tick    1-cycle enable at OVERSAMPLE x baud
//   rx          serial input, idle high, asynchronous
//   rx_ack      consumer read rx_data; clears rx_valid/overrun
//   rx_data     last good byte
//   rx_valid    rx_data holds an unread byte
//   overrun     sticky: byte completed while rx_valid was set
//   framing_err 1-cycle pulse: stop bit low, byte dropped
//   parity_err  1-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
//   busy        FSM not idle
module uart_rx_core #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 sam_tick,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t state, state_n;

  logic                 rx_q;
  logic                 rx_s;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 stop_ok;
  logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  assign busy = (state != S_IDLE);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= rx;
      rx_s <= rx_q;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bcnt_n   = bcnt;
    shreg_n  = shreg;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad  = 1'b0;
`endif
    if (sam_tick) begin
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_n = S_START;
            tcnt_n  = '0;
          end
        end
        // Mid start bit: line back high means it was a glitch.
        S_START: begin
          if (tcnt == T_MID) begin
            tcnt_n  = '0;
            bcnt_n  = '0;
            state_n = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        // LSB first: each sample enters at the MSB and shifts down.
        S_DATA: begin
          if (tcnt == T_END) begin
            tcnt_n  = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            if (bcnt == B_END) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
            end else begin
              bcnt_n = bcnt + BW'(1);
            end
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        S_PARITY: begin
          if (tcnt == T_END) begin
            tcnt_n  = '0;
            par_bad = ^{shreg, rx_s};
            state_n = S_STOP;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
`endif
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        S_STOP: begin
          if (tcnt == T_END) begin
            tcnt_n   = '0;
            state_n  = S_IDLE;
            stop_ok  = rx_s;
            stop_bad = ~rx_s;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // A completing byte wins over a same-cycle ack; the ack then clears overrun.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= stop_bad;
      if (stop_ok) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        overrun  <= ~rx_ack & (rx_valid | overrun);
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_bad;
    end
  end
`endif

endmodule
